// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code encoder/decoder family: FSM state
// encoding and reference conversion functions.
package gray_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Whole-word binary to Gray conversion (up to 16 bits)
    function automatic logic [15:0] bin2gry(input logic [15:0] w);
        return w ^ (w >> 1);
    endfunction

    // Whole-word Gray to binary conversion (up to 16 bits), MSB first
    function automatic logic [15:0] gry2bin(input logic [15:0] g);
        logic [15:0] b;
        b[15] = g[15];
        for (int i = 14; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/bin_to_gry_serial.sv
// Bit-serial binary-to-Gray encoder. A word is accepted in IDLE, one Gray
// bit is produced per clock MSB first in CALC, and the finished word is
// held on a valid/ready output in OUT until downstream takes it.
module bin_to_gry_serial
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] bin_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gry_out,
    output logic             busy
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_shr;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_next;
    logic [IDX_W-1:0] n;
    logic             accept;

    // bin_shr[n] is bin_q[n+1] with an implicit zero above the MSB
    assign bin_shr = bin_q >> 1;
    assign accept  = in_valid && (state == IDLE);

    // Handshake and status outputs are pure decodes of the state register
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign busy      = (state == CALC) || (state == OUT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; unknown encodings fall back to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)     state_next = CALC;
            CALC: if (n == '0)    state_next = OUT;
            OUT:  if (out_ready)  state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    // Work word with the current bit position filled in
    always_comb begin
        work_next    = work;
        work_next[n] = bin_q[n] ^ bin_shr[n];
    end

    // Captured word, partial result, bit index and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q   <= '0;
            work    <= '0;
            n       <= '0;
            gry_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bin_q <= bin_in;
                        work  <= '0;
                        n     <= LAST_IDX;
                    end
                end
                CALC: begin
                    work <= work_next;
                    if (n == '0) begin
                        gry_out <= work_next;
                    end else begin
                        n <= n - IDX_W'(1);
                    end
                end
                OUT: begin
                end
                default: begin
                    bin_q   <= '0;
                    work    <= '0;
                    n       <= '0;
                    gry_out <= '0;
                end
            endcase
        end
    end

endmodule
